// File: rtl/game_pkg.sv
// Shared game constants: direction indices (also the btn_state bit positions),
// default timing values and the move-direction priority picker.
package game_pkg;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;
  localparam int NUM_DIRS  = 4;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 20_000_000;

  typedef logic [NUM_DIRS-1:0] dir_vec_t;

  // One-hot grant of the lowest set index, so up beats down beats left beats right.
  function automatic dir_vec_t pick_priority(input dir_vec_t req);
    dir_vec_t grant;
    grant = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: synchroniser chain, debounce counter, armed flag and stable level.
// rise is high in the cycle before stable goes 0->1, so callers can register a pulse on that edge.
module btn_debounce
  import game_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic armed,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   synced;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          zero_cnt;
  logic                   accept;

  assign synced = sync_chain[SYNC_STAGES-1];
  assign accept = (synced != stable) && (cnt == LAST);
  assign rise   = accept && synced;

  always_ff @(posedge clk) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Arming needs a confirmed released level, so a button held through reset cannot fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt <= '0;
      armed    <= 1'b0;
    end else if (!armed) begin
      if (synced)                zero_cnt <= '0;
      else if (zero_cnt == LAST) armed    <= 1'b1;
      else                       zero_cnt <= zero_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/move_pulse_gen.sv
// Button-to-move-pulse conditioner: four debouncers, priority arbiter, pause gating, output pulses.
// Define AUTO_REPEAT_EN to add per-button hold timers that re-fire while a button stays held.
module move_pulse_gen
  import game_pkg::*;
#(
`ifdef AUTO_REPEAT_EN
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] btn_state
);

  dir_vec_t raw, stable, armed, rise, press, event_req, grant, pulse_q;

  assign raw[DIR_UP]    = btn_up;
  assign raw[DIR_DOWN]  = btn_down;
  assign raw[DIR_LEFT]  = btn_left;
  assign raw[DIR_RIGHT] = btn_right;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .stable(stable[i]),
      .armed (armed[i]),
      .rise  (rise[i])
    );
  end

  assign press = rise & armed;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt [NUM_DIRS];
  dir_vec_t      tracking, periodic, repeat_hit;

  always_comb begin
    repeat_hit = '0;
    for (int i = 0; i < NUM_DIRS; i++)
      repeat_hit[i] = tracking[i] && (hold_cnt[i] == (periodic[i] ? PERIOD_LAST : DELAY_LAST));
  end

  // Only a real press starts the schedule; a repeat advances it even if the arbiter drops it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (reset || pause) begin
        tracking[i] <= 1'b0;
        periodic[i] <= 1'b0;
        hold_cnt[i] <= '0;
      end else if (press[i]) begin
        tracking[i] <= 1'b1;
        periodic[i] <= 1'b0;
        hold_cnt[i] <= '0;
      end else if (!stable[i]) begin
        tracking[i] <= 1'b0;
        periodic[i] <= 1'b0;
        hold_cnt[i] <= '0;
      end else if (repeat_hit[i]) begin
        periodic[i] <= 1'b1;
        hold_cnt[i] <= '0;
      end else if (tracking[i]) begin
        hold_cnt[i] <= hold_cnt[i] + HW'(1);
      end
    end
  end

  assign event_req = press | repeat_hit;
`else
  assign event_req = press;
`endif

  assign grant = pause ? '0 : pick_priority(event_req);

  always_ff @(posedge clk) begin
    if (reset) pulse_q <= '0;
    else       pulse_q <= grant;
  end

  assign up        = pulse_q[DIR_UP];
  assign down      = pulse_q[DIR_DOWN];
  assign left      = pulse_q[DIR_LEFT];
  assign right     = pulse_q[DIR_RIGHT];
  assign btn_state = stable;

endmodule

// File: tb/tb_move_pulse_gen.sv
// Bench for move_pulse_gen: directed scenarios plus random buttons/pause against a
// sliding-window reference model (AUTO_REPEAT_EN adds the hold-schedule model).
module tb_move_pulse_gen;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int HN = SS + DC;
`ifdef AUTO_REPEAT_EN
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int HOLD_PULSES = 6;
  localparam int HOLD_LAST   = 58;
`else
  localparam int HOLD_PULSES = 1;
  localparam int HOLD_LAST   = 6;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, pause = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic up, down, left, right;
  logic [3:0] btn_state;

  int checks = 0, errors = 0;

  move_pulse_gen #(
`ifdef AUTO_REPEAT_EN
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
`endif
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pause    (pause),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DC synchronised samples all agree on it.
  logic       hist [4][HN];
  logic [3:0] m_stable, m_armed, m_track, m_raw, m_ev;
  logic [3:0] exp_pulse = '0, exp_state = '0;
  logic       m_all0, m_all1, m_old, m_pressed;
  int         since = 0, edge_no = 0, m_age;
  int         m_press_at [4];

  always @(posedge clk) begin
    edge_no++;
    m_raw = {btn_right, btn_left, btn_down, btn_up};
    m_ev  = '0;
    if (reset) begin
      since    = 0;
      m_stable = '0;
      m_armed  = '0;
      m_track  = '0;
      for (int d = 0; d < 4; d++)
        for (int k = 0; k < HN; k++) hist[d][k] = 1'b0;
      exp_pulse = '0;
    end else begin
      since++;
      for (int d = 0; d < 4; d++) begin
        for (int k = 0; k < HN - 1; k++) hist[d][k] = hist[d][k+1];
        hist[d][HN-1] = m_raw[d];
        m_all0 = 1'b1;
        m_all1 = 1'b1;
        for (int k = 0; k < DC; k++) begin
          if (hist[d][k]) m_all0 = 1'b0;
          else            m_all1 = 1'b0;
        end
        m_old     = m_stable[d];
        m_pressed = 1'b0;
        if (!m_old && m_all1) begin
          m_stable[d] = 1'b1;
          m_pressed   = m_armed[d];
        end else if (m_old && m_all0) begin
          m_stable[d] = 1'b0;
        end
        if (since >= DC && m_all0) m_armed[d] = 1'b1;
        m_ev[d] = m_pressed;
`ifdef AUTO_REPEAT_EN
        if (pause) m_track[d] = 1'b0;
        else if (m_pressed) begin
          m_track[d]    = 1'b1;
          m_press_at[d] = edge_no;
        end else if (!m_old) m_track[d] = 1'b0;
        else if (m_track[d]) begin
          m_age = edge_no - m_press_at[d];
          if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) m_ev[d] = 1'b1;
        end
`endif
      end
      exp_pulse = '0;
      if (!pause)
        for (int d = 3; d >= 0; d--)
          if (m_ev[d]) begin
            exp_pulse    = '0;
            exp_pulse[d] = 1'b1;
          end
    end
    exp_state = m_stable;
  end

  int    cyc, diverge, multi;
  int    obs_cnt [4], first_at [4], last_at [4];
  string div_msg;

  task automatic set_buttons(input logic [3:0] v);
    {btn_right, btn_left, btn_down, btn_up} = v;
  endtask

  task automatic clear_obs();
    cyc = 0; diverge = 0; multi = 0; div_msg = "";
    for (int d = 0; d < 4; d++) begin
      obs_cnt[d] = 0; first_at[d] = -1; last_at[d] = -1;
    end
  endtask

  // Advances n cycles, recording observed pulses and any disagreement with the model.
  task automatic tick(input int n);
    logic [3:0] obs;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      obs = {right, left, down, up};
      if (obs !== exp_pulse || btn_state !== exp_state) begin
        if (diverge == 0)
          div_msg = $sformatf("first at cycle %0d: pulses %b vs %b, btn_state %b vs %b", cyc, obs, exp_pulse, btn_state, exp_state);
        diverge++;
      end
      if ($countones(obs) > 1) multi++;
      for (int d = 0; d < 4; d++)
        if (obs[d] === 1'b1) begin
          obs_cnt[d]++;
          if (first_at[d] < 0) first_at[d] = cyc;
          last_at[d] = cyc;
        end
    end
  endtask

  task automatic restart();
    reset = 1'b1; pause = 1'b0; set_buttons(4'b0000);
    tick(2);
    reset = 1'b0;
    tick(10 + int'($urandom_range(0, 5)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_buttons(4'($urandom_range(0, 15)));
    clear_obs();
    tick(3);
    checks++; if ({right, left, down, up} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses: got %b, expected 0000", {right, left, down, up}); end
    checks++; if (btn_state !== 4'b0000) begin errors++; $display("[TB] FAIL reset_state: got %b, expected 0000", btn_state); end
    reset = 1'b0; set_buttons(4'b0000);
    clear_obs();
    tick(12);
    checks++; if (obs_cnt.sum() !== 0) begin errors++; $display("[TB] FAIL reset_idle_pulses: got %0d, expected 0", obs_cnt.sum()); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL reset_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
  endtask

  task automatic test_press_latency();
    restart(); clear_obs();
    set_buttons(4'b1000);
    tick(100);
    checks++; if (obs_cnt[3] !== 1) begin errors++; $display("[TB] FAIL latency_right_count: got %0d, expected 1", obs_cnt[3]); end
    checks++; if (first_at[3] !== SS + DC) begin errors++; $display("[TB] FAIL latency_right_edge: got %0d, expected %0d", first_at[3], SS + DC); end
    checks++; if (obs_cnt[0] + obs_cnt[1] + obs_cnt[2] !== 0) begin errors++; $display("[TB] FAIL latency_others: got %0d, expected 0", obs_cnt[0] + obs_cnt[1] + obs_cnt[2]); end
    checks++; if (btn_state[3] !== 1'b1) begin errors++; $display("[TB] FAIL latency_state: got %b, expected 1", btn_state[3]); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL latency_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
    set_buttons(4'b0000); tick(10);
  endtask

  task automatic test_bounce();
    restart(); clear_obs();
    for (int s = 0; s < 10; s++) begin
      btn_up = (s % 2 == 0);
      tick(int'($urandom_range(1, DC - 1)));
    end
    checks++; if (obs_cnt[0] !== 0) begin errors++; $display("[TB] FAIL bounce_early: got %0d, expected 0", obs_cnt[0]); end
    clear_obs();
    btn_up = 1'b1;
    tick(30);
    checks++; if (obs_cnt[0] !== 1) begin errors++; $display("[TB] FAIL bounce_count: got %0d, expected 1", obs_cnt[0]); end
    checks++; if (first_at[0] !== SS + DC) begin errors++; $display("[TB] FAIL bounce_edge: got %0d, expected %0d", first_at[0], SS + DC); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL bounce_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
  endtask

  task automatic test_arbitration();
    restart(); clear_obs();
    set_buttons(4'b0101);
    tick(20);
    checks++; if (obs_cnt[0] !== 1) begin errors++; $display("[TB] FAIL arb_up_count: got %0d, expected 1", obs_cnt[0]); end
    checks++; if (obs_cnt[2] !== 0) begin errors++; $display("[TB] FAIL arb_left_count: got %0d, expected 0", obs_cnt[2]); end
    clear_obs();
    set_buttons(4'b0100);
    tick(20);
    checks++; if (obs_cnt.sum() !== 0) begin errors++; $display("[TB] FAIL arb_left_after_up: got %0d, expected 0", obs_cnt.sum()); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL arb_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
    set_buttons(4'b0000); tick(10);
  endtask

  task automatic test_pause();
    restart(); clear_obs();
    pause = 1'b1;
    set_buttons(4'b0010);
    tick(20);
    pause = 1'b0;
    tick(20);
    checks++; if (obs_cnt.sum() !== 0) begin errors++; $display("[TB] FAIL pause_held: got %0d, expected 0", obs_cnt.sum()); end
    set_buttons(4'b0000); tick(10);
    clear_obs();
    set_buttons(4'b0010);
    tick(20);
    checks++; if (obs_cnt[1] !== 1) begin errors++; $display("[TB] FAIL pause_repress_count: got %0d, expected 1", obs_cnt[1]); end
    checks++; if (first_at[1] !== SS + DC) begin errors++; $display("[TB] FAIL pause_repress_edge: got %0d, expected %0d", first_at[1], SS + DC); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL pause_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
    set_buttons(4'b0000); tick(10);
  endtask

  task automatic test_reset_hold();
    restart();
    set_buttons(4'b0100);
    tick(20);
    reset = 1'b1; tick(1); reset = 1'b0;
    clear_obs();
    tick(50);
    checks++; if (obs_cnt.sum() !== 0) begin errors++; $display("[TB] FAIL rsthold_held: got %0d, expected 0", obs_cnt.sum()); end
    set_buttons(4'b0000); tick(10);
    clear_obs();
    set_buttons(4'b0100);
    tick(20);
    checks++; if (obs_cnt[2] !== 1) begin errors++; $display("[TB] FAIL rsthold_repress: got %0d, expected 1", obs_cnt[2]); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL rsthold_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
    set_buttons(4'b0000); tick(10);
  endtask

  task automatic test_hold();
    restart(); clear_obs();
    set_buttons(4'b1000);
    tick(58);
    set_buttons(4'b0000);
    tick(20);
    checks++; if (obs_cnt[3] !== HOLD_PULSES) begin errors++; $display("[TB] FAIL hold_count: got %0d, expected %0d", obs_cnt[3], HOLD_PULSES); end
    checks++; if (last_at[3] !== HOLD_LAST) begin errors++; $display("[TB] FAIL hold_last_edge: got %0d, expected %0d", last_at[3], HOLD_LAST); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL hold_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
  endtask

  task automatic test_random();
    restart(); clear_obs();
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 4; d++)
        if ($urandom_range(0, 7) == 0) begin
          case (d)
            0: btn_up    = ~btn_up;
            1: btn_down  = ~btn_down;
            2: btn_left  = ~btn_left;
            default: btn_right = ~btn_right;
          endcase
        end
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      reset = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    reset = 1'b0;
    checks++; if (multi !== 0) begin errors++; $display("[TB] FAIL random_onehot: got %0d multi-pulse cycles, expected 0", multi); end
    checks++; if (diverge !== 0) begin errors++; $display("[TB] FAIL random_model: %0d cycles differ, expected 0; %s", diverge, div_msg); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_arbitration();
    test_pause();
    test_reset_hold();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
